// File: rtl/img_pkg.sv
// Shared pixel widths, FSM states and the 4-neighbour kernel
// used by the Laplacian detail stream.
package img_pkg;

  localparam int PIX_W = 8;
  localparam int DET_W = 20;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    FLUSH
  } state_e;

  function automatic logic signed [DET_W-1:0] lap4(
    input logic [PIX_W-1:0] c,
    input logic [PIX_W-1:0] n,
    input logic [PIX_W-1:0] s,
    input logic [PIX_W-1:0] e,
    input logic [PIX_W-1:0] w
  );
    int v;
    v = 4 * int'(c) - int'(n) - int'(s)
      - int'(e) - int'(w);
    return DET_W'(v);
  endfunction

endpackage

// File: rtl/laplacian_stream_if.sv
// Pixel in / detail out stream bundle with
// valid/ready handshakes on both sides.
interface laplacian_stream_if;
  import img_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pix;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_pix;
  logic [DET_W-1:0] out_detail;
  logic             out_eol;

  modport slave (
    input  in_valid, in_pix, out_ready,
    output in_ready, out_valid, out_pix,
    output out_detail, out_eol
  );

  modport master (
    output in_valid, in_pix, out_ready,
    input  in_ready, out_valid, out_pix,
    input  out_detail, out_eol
  );

endinterface

// File: rtl/line_buffer.sv
// One-row pixel delay: dout_o is the pixel pushed
// DEPTH enabled cycles ago. Contents are never cleared.
module line_buffer #(
  parameter int DEPTH = 64,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [PIX_W-1:0] din_i,
  output logic [PIX_W-1:0] dout_o
);

  logic [PIX_W-1:0] sr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en_i) begin
      sr_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/laplacian_stream.sv
// Streaming 4-neighbour Laplacian: emits the center pixel
// and its signed detail, one output per input pixel.
module laplacian_stream
  import img_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input logic         clk,
  input logic         rst,
  laplacian_stream_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] CMAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RMAX = RW'(IMG_H - 1);

  state_e state_q, state_d;

  logic [CW-1:0] icol_q, icol_d;
  logic [RW-1:0] irow_q, irow_d;
  logic [CW-1:0] ocol_q, ocol_d;
  logic [RW-1:0] orow_q, orow_d;

  logic [PIX_W-1:0] s_q, s_d;
  logic [PIX_W-1:0] c_q, c_d;
  logic [PIX_W-1:0] w_q, w_d;
  logic [PIX_W-1:0] n_q, n_d;

  logic                    ov_q, ov_d;
  logic [PIX_W-1:0]        opix_q, opix_d;
  logic signed [DET_W-1:0] odet_q, odet_d;
  logic                    oeol_q, oeol_d;

  logic [PIX_W-1:0] e_tap;
  logic [PIX_W-1:0] n_tap;

  logic load_ok;
  logic rdy;
  logic acc;
  logic flush_ld;
  logic emit;
  logic adv;
  logic border;

  // Row 1 buffer yields E (k-W); row 2 yields k-2W, N after one tap.
  line_buffer #(
    .DEPTH (IMG_W),
    .PIX_W (PIX_W)
  ) u_lb0 (
    .clk    (clk),
    .en_i   (adv),
    .din_i  (bus.in_pix),
    .dout_o (e_tap)
  );

  line_buffer #(
    .DEPTH (IMG_W),
    .PIX_W (PIX_W)
  ) u_lb1 (
    .clk    (clk),
    .en_i   (adv),
    .din_i  (e_tap),
    .dout_o (n_tap)
  );

  assign load_ok  = !ov_q || bus.out_ready;
  assign rdy      = !rst && (state_q != FLUSH)
                  && load_ok;
  assign acc      = bus.in_valid && rdy;
  assign flush_ld = (state_q == FLUSH) && load_ok;
  assign emit     = (acc && state_q == RUN)
                  || flush_ld;
  assign adv      = acc || flush_ld;
  assign border   = (orow_q == '0) || (orow_q == RMAX)
                  || (ocol_q == '0) || (ocol_q == CMAX);

  always_comb begin
    state_d = state_q;
    icol_d  = icol_q;
    irow_d  = irow_q;
    ocol_d  = ocol_q;
    orow_d  = orow_q;
    s_d     = s_q;
    c_d     = c_q;
    w_d     = w_q;
    n_d     = n_q;
    ov_d    = ov_q;
    opix_d  = opix_q;
    odet_d  = odet_q;
    oeol_d  = oeol_q;

    if (adv) begin
      s_d = bus.in_pix;
      c_d = e_tap;
      w_d = c_q;
      n_d = n_tap;
    end

    if (acc) begin
      icol_d = (icol_q == CMAX) ? '0 : icol_q + CW'(1);
      if (icol_q == CMAX) begin
        irow_d = (irow_q == RMAX) ? '0 : irow_q + RW'(1);
      end
    end

    if (emit) begin
      ov_d   = 1'b1;
      opix_d = c_q;
      odet_d = border ? '0
             : lap4(c_q, n_q, s_q, e_tap, w_q);
      oeol_d = (ocol_q == CMAX);
      ocol_d = (ocol_q == CMAX) ? '0 : ocol_q + CW'(1);
      if (ocol_q == CMAX) begin
        orow_d = (orow_q == RMAX) ? '0 : orow_q + RW'(1);
      end
    end else if (bus.out_ready) begin
      ov_d = 1'b0;
    end

    unique case (state_q)
      FILL: begin
        if (acc && irow_q == RW'(1) && icol_q == '0) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (acc && irow_q == RMAX && icol_q == CMAX) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_ld && orow_q == RMAX && ocol_q == CMAX) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      icol_q  <= '0;
      irow_q  <= '0;
      ocol_q  <= '0;
      orow_q  <= '0;
      s_q     <= '0;
      c_q     <= '0;
      w_q     <= '0;
      n_q     <= '0;
      ov_q    <= 1'b0;
      opix_q  <= '0;
      odet_q  <= '0;
      oeol_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      icol_q  <= icol_d;
      irow_q  <= irow_d;
      ocol_q  <= ocol_d;
      orow_q  <= orow_d;
      s_q     <= s_d;
      c_q     <= c_d;
      w_q     <= w_d;
      n_q     <= n_d;
      ov_q    <= ov_d;
      opix_q  <= opix_d;
      odet_q  <= odet_d;
      oeol_q  <= oeol_d;
    end
  end

  assign bus.in_ready   = rdy;
  assign bus.out_valid  = ov_q;
  assign bus.out_pix    = opix_q;
  assign bus.out_detail = odet_q;
  assign bus.out_eol    = oeol_q;

endmodule

// File: tb/tb_laplacian_stream.sv
// Randomized scoreboard bench for laplacian_stream on
// an 8x8 image with a frame-level reference model.
module tb_laplacian_stream;
  import img_pkg::*;

  localparam int W = 8;
  localparam int H = 8;
  localparam int N = W * H;

  typedef struct packed {
    logic [7:0]  pix;
    logic [19:0] det;
    logic        eol;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  laplacian_stream_if bus ();

  laplacian_stream #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  bit         ignore = 1'b0;
  int         rdy_mode = 0;
  logic [7:0] fr [N];
  bit         stalled = 1'b0;
  exp_t       held;
  exp_t       got;
  exp_t       ex;
  int         w0;

  function automatic exp_t ref_out(input int idx);
    exp_t e;
    int r = idx / W;
    int c = idx % W;
    int d = 0;
    if (r > 0 && r < H-1 && c > 0 && c < W-1) begin
      d = 4 * int'(fr[idx])
        - int'(fr[idx-W]) - int'(fr[idx+W])
        - int'(fr[idx-1]) - int'(fr[idx+1]);
    end
    e.pix = fr[idx];
    e.det = 20'(d);
    e.eol = (c == W-1);
    return e;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, req);
    end
  endtask

  task automatic send_px(input logic [7:0] p,
                         input int gap,
                         output int waits);
    bit ok = 1'b0;
    waits = 0;
    while (gap > 0 && $urandom_range(99) < gap) begin
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_pix   = p;
    while (!ok) begin
      @(negedge clk);
      ok = bus.in_ready;
      if (!ok) waits++;
      if (waits > 500) begin
        $display("FAIL accept_timeout got=stuck want=ready");
        $fatal(1, "input never accepted");
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int gap,
                           input bit keep,
                           output int first_wait);
    int w;
    first_wait = 0;
    for (int i = 0; i < N; i++) sb.push_back(ref_out(i));
    for (int i = 0; i < N; i++) begin
      send_px(fr[i], gap, w);
      if (i == 0) first_wait = w;
    end
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && sb.size() != 0; i++) begin
      @(posedge clk);
    end
    #1;
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic reset_chk();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_pix", bus.out_pix, 0);
    chk("rst_out_detail", bus.out_detail, 0);
    chk("rst_out_eol", bus.out_eol, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b0;
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = (rdy_mode == 0) ? 1'b1
                    : 1'($urandom_range(1));
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      got = {bus.out_pix, bus.out_detail, bus.out_eol};
      if (rst || ignore) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        total++;
        if (!bus.out_valid || got !== held) begin
          bad++;
          $display("FAIL hold got=%h want=%h", got, held);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        total++;
        stalled = 1'b0;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL extra_out got=%h want=none", got);
        end else begin
          ex = sb.pop_front();
          if (got !== ex) begin
            bad++;
            $display("FAIL out got=%h want=%h", got, ex);
          end
        end
      end else begin
        stalled = bus.out_valid;
        held    = got;
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_pix   = '0;
    reset_chk();

    // constant frame, no backpressure
    for (int i = 0; i < N; i++) fr[i] = 8'd100;
    run_frame(0, 1'b0, w0);
    drain();

    // single bright pixel
    for (int i = 0; i < N; i++) fr[i] = 8'd0;
    fr[3*W+3] = 8'd200;
    run_frame(20, 1'b0, w0);
    drain();

    // ramp with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < N; i++) fr[i] = 8'(i);
    run_frame(15, 1'b0, w0);
    drain();

    // random frames, random gaps and stalls
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) fr[i] = 8'($urandom);
      run_frame(25, 1'b0, w0);
    end
    drain();

    // abort a frame with reset, then a clean frame
    rdy_mode = 0;
    ignore = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send_px(8'($urandom), 0, w0);
    end
    reset_chk();
    ignore = 1'b0;
    for (int i = 0; i < N; i++) fr[i] = 8'd50;
    run_frame(0, 1'b0, w0);
    drain();

    // back-to-back frames, in_valid held high
    for (int i = 0; i < N; i++) fr[i] = 8'($urandom);
    run_frame(0, 1'b1, w0);
    for (int i = 0; i < N; i++) fr[i] = 8'($urandom);
    run_frame(0, 1'b0, w0);
    chk("flush_gap", w0, 9);
    drain();

    repeat (20) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
